// File: rtl/mc_main_control.sv
// mc_main_control -- multicycle main control FSM.
//
// Sequences fetch, decode, execute, memory and writeback for a small
// MIPS-like instruction set. It drives every datapath enable and mux select,
// plus the 3-bit ALUOp consumed by the downstream ALU control decoder.
// All outputs are Moore outputs decoded from the current state. While rst
// is high they are forced inactive, with ALUOp = 010.
//
// Ports:
//   clk, rst           rising-edge clock; asynchronous active-high reset
//   opcode[5:0]        IR[31:26], sampled in DECODE, MEMADR and IEXEC
//   PCWrite            unconditional PC load
//   PCWriteCond        PC load qualified by ALU zero
//   IorD               memory address select (0=PC, 1=ALUOut)
//   MemRead/MemWrite   memory strobes
//   MemtoReg           register write data select (1=MDR, 0=ALUOut)
//   IRWrite            IR load
//   RegDst             destination select (1=rd, 0=rt)
//   RegWrite           register file write
//   ALUSrcA            0=PC, 1=A
//   ALUSrcB[1:0]       00=B, 01=4, 10=ext imm, 11=ext imm<<2
//   PCSource[1:0]      00=ALU, 01=ALUOut, 10=jump target
//   ALUOp[2:0]         000 R-type, 001 sub, 010 add, 011 and, 100 or
//   instr_done         one-cycle pulse in an instruction's final state
//   illegal_op         sticky illegal-opcode flag
//
// Optional feature macro: MC_ILLEGAL_TRAP_EN. When it is defined, an
// unknown opcode parks the FSM in TRAP until reset and raises illegal_op.
// When it is undefined, an unknown opcode is a 2-cycle NOP and illegal_op
// is tied to 0.
module mc_main_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t state_q, state_d;

  // State register; reset parks the FSM in FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:               state_d = S_MEMADR;
          OP_RTYPE:                   state_d = S_RTEXEC;
          OP_ADDI, OP_ANDI, OP_ORI:   state_d = S_IEXEC;
          OP_BEQ:                     state_d = S_BRANCH;
          OP_J:                       state_d = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
          default:                    state_d = S_TRAP;
`else
          default:                    state_d = S_FETCH;  // unknown opcode is a NOP
`endif
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_RTEXEC: state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;   // only reset leaves TRAP
`endif
      default:  state_d = S_FETCH;  // unencoded states recover to FETCH
    endcase
  end

  // Moore output decode. rst overrides the decode so that outputs go
  // inactive immediately, not one edge later.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 3'b010;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (rst) begin
      ALUOp = 3'b010;
    end else begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          ALUSrcB = 2'b01;
          PCWrite = 1'b1;
        end
        S_DECODE: ALUSrcB = 2'b11;  // precompute the branch target
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = 1'b1;
        end
        S_RTEXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 3'b000;
        end
        S_RTWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          case (opcode)
            OP_ANDI: ALUOp = 3'b011;
            OP_ORI:  ALUOp = 3'b100;
            default: ALUOp = 3'b010;
          endcase
        end
        S_IWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 3'b001;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
`ifdef MC_ILLEGAL_TRAP_EN
        S_TRAP: illegal_op = 1'b1;  // TRAP is held until reset, so the flag is sticky
`endif
        default: ALUOp = 3'b010;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_main_control.sv
module tb_mc_main_control;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;

  int checks_cnt = 0;
  int errors_cnt = 0;

  mc_main_control dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle, order:
  // PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite RegDst
  // RegWrite ALUSrcA ALUSrcB[2] PCSource[2] ALUOp[3] instr_done illegal_op
  logic [18:0] outv;
  assign outv = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                 IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
                 ALUOp, instr_done, illegal_op};

  //                                 PW    PWC   IorD  MR    MW    M2R   IRW   RD    RW    SA    SB     PCS    AOP     DN    ILL
  localparam logic [18:0] V_ZERO   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam logic [18:0] V_TRAP   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1};
  localparam logic [18:0] V_FETCH  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam logic [18:0] V_DECODE = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam logic [18:0] V_MEMADR = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam logic [18:0] V_MEMRD  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam logic [18:0] V_MEMWB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0};
  localparam logic [18:0] V_MEMWR  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0};
  localparam logic [18:0] V_RTEXEC = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] V_RTWB   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0};
  localparam logic [18:0] V_IEXADD = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam logic [18:0] V_IEXAND = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 3'b011, 1'b0, 1'b0};
  localparam logic [18:0] V_IEXOR  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 3'b100, 1'b0, 1'b0};
  localparam logic [18:0] V_IWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0};
  localparam logic [18:0] V_BRANCH = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 3'b001, 1'b1, 1'b0};
  localparam logic [18:0] V_JUMP   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 3'b010, 1'b1, 1'b0};

  // Single comparison point: counts the check, reports a mismatch.
  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    checks_cnt++;
    if (observed !== expected) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%05h, expected 0x%05h", tag, observed, expected);
    end
  endtask

  // Check the current cycle's outputs, then advance to 1 time unit past the next edge.
  task automatic step(input string tag, input logic [18:0] expv);
    check_eq(tag, {13'd0, outv}, {13'd0, expv});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", {13'd0, outv}, {13'd0, V_ZERO});
    rst = 1'b0;
    #1;

    // lw: 5 cycles, writeback only in the last one
    opcode = 6'b100011;
    step("lw_fetch",  V_FETCH);
    step("lw_decode", V_DECODE);
    step("lw_memadr", V_MEMADR);
    step("lw_memrd",  V_MEMRD);
    step("lw_memwb",  V_MEMWB);

    // R-type then ori: 4 cycles each
    opcode = 6'b000000;
    step("rt_fetch",  V_FETCH);
    step("rt_decode", V_DECODE);
    step("rt_exec",   V_RTEXEC);
    step("rt_wb",     V_RTWB);
    opcode = 6'b001101;
    step("ori_fetch",  V_FETCH);
    step("ori_decode", V_DECODE);
    step("ori_exec",   V_IEXOR);
    step("ori_wb",     V_IWB);

    // addi and andi select their ALU operations
    opcode = 6'b001000;
    step("addi_fetch",  V_FETCH);
    step("addi_decode", V_DECODE);
    step("addi_exec",   V_IEXADD);
    step("addi_wb",     V_IWB);
    opcode = 6'b001100;
    step("andi_fetch",  V_FETCH);
    step("andi_decode", V_DECODE);
    step("andi_exec",   V_IEXAND);
    step("andi_wb",     V_IWB);

    // beq then j: 3 cycles each
    opcode = 6'b000100;
    step("beq_fetch",  V_FETCH);
    step("beq_decode", V_DECODE);
    step("beq_branch", V_BRANCH);
    opcode = 6'b000010;
    step("j_fetch",  V_FETCH);
    step("j_decode", V_DECODE);
    step("j_jump",   V_JUMP);

    // sw: 4 cycles, no register write
    opcode = 6'b101011;
    step("sw_fetch",  V_FETCH);
    step("sw_decode", V_DECODE);
    step("sw_memadr", V_MEMADR);
    step("sw_memwr",  V_MEMWR);

    // Illegal opcode
    opcode = 6'b111111;
    step("ill_fetch",  V_FETCH);
    step("ill_decode", V_DECODE);
`ifdef MC_ILLEGAL_TRAP_EN
    step("ill_trap0", V_TRAP);
    step("ill_trap1", V_TRAP);
    step("ill_trap2", V_TRAP);
    check_eq("ill_flag", {31'd0, illegal_op}, 32'd1);
`else
    check_eq("ill_flag", {31'd0, illegal_op}, 32'd0);
    step("ill_nop_fetch", V_FETCH);
    step("ill_nop_decode", V_DECODE);
`endif

    // Reset pulse from wherever the FSM is
    rst = 1'b1;
    #1;
    check_eq("rst_pulse", {13'd0, outv}, {13'd0, V_ZERO});
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset mid-MEMRD: outputs drop immediately; recovery starts at FETCH
    opcode = 6'b100011;
    step("mr_fetch",  V_FETCH);
    step("mr_decode", V_DECODE);
    step("mr_memadr", V_MEMADR);
    check_eq("mr_memrd", {13'd0, outv}, {13'd0, V_MEMRD});
    #2;
    rst = 1'b1;
    #1;
    check_eq("mr_rst_immediate", {13'd0, outv}, {13'd0, V_ZERO});
    @(posedge clk);
    #1;
    check_eq("mr_rst_held", {13'd0, outv}, {13'd0, V_ZERO});
    rst = 1'b0;
    #1;
    step("mr_post_fetch",  V_FETCH);
    step("mr_post_decode", V_DECODE);
    step("mr_post_memadr", V_MEMADR);
    step("mr_post_memrd",  V_MEMRD);
    step("mr_post_memwb",  V_MEMWB);
    step("mr_post_next",   V_FETCH);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
